// File: rtl/branch_predict_unit_if.sv
// Bundles the fetch lookup, execute-stage resolve and status/statistics signals of the
// branch predict unit so that producer and unit connect through one port.
interface branch_predict_unit_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
);
  logic [WIDTH-1:0] lookup_pc;
  logic             pred_taken;
  logic             resolve_valid;
  logic [WIDTH-1:0] resolve_pc;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic [2:0]       funct3;
  logic             pred_in;
  logic             clear_stats;
  logic             valid_q;
  logic             taken_q;
  logic             mispredict_q;
  logic             illegal_q;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output lookup_pc, resolve_valid, resolve_pc, rs1, rs2, funct3, pred_in, clear_stats,
    input  pred_taken, valid_q, taken_q, mispredict_q, illegal_q, branch_cnt, mispred_cnt
  );

  modport slave (
    input  lookup_pc, resolve_valid, resolve_pc, rs1, rs2, funct3, pred_in, clear_stats,
    output pred_taken, valid_q, taken_q, mispredict_q, illegal_q, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Resolves RV branch conditions, trains a PC-indexed table of 2-bit saturating counters
// that feeds fetch predictions, and keeps saturating branch/mispredict statistics.
module branch_predict_unit #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]       table_q [DEPTH];
  logic [1:0]       entry_d;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] resolve_idx;

  logic             cond_taken;
  logic             cond_legal;
  logic             legal_resolve;

  logic             valid_d, valid_q;
  logic             taken_d, taken_q;
  logic             mispredict_d, mispredict_q;
  logic             illegal_d, illegal_q;
  logic [CNT_W-1:0] branch_cnt_d, branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_d, mispred_cnt_q;

  // Only the word-aligned index bits of either PC select a table entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc, bus.resolve_pc};

  assign lookup_idx  = bus.lookup_pc[IDX_W+1:2];
  assign resolve_idx = bus.resolve_pc[IDX_W+1:2];

  // Reads the registered table, so a same-cycle update to this entry is not visible yet.
  assign bus.pred_taken = table_q[lookup_idx][1];

  always_comb begin
    cond_taken = 1'b0;
    cond_legal = 1'b1;
    case (bus.funct3)
      3'b000:  cond_taken = (bus.rs1 == bus.rs2);
      3'b001:  cond_taken = (bus.rs1 != bus.rs2);
      3'b100:  cond_taken = ($signed(bus.rs1) <  $signed(bus.rs2));
      3'b101:  cond_taken = ($signed(bus.rs1) >= $signed(bus.rs2));
      3'b110:  cond_taken = (bus.rs1 <  bus.rs2);
      3'b111:  cond_taken = (bus.rs1 >= bus.rs2);
      default: cond_legal = 1'b0;
    endcase
  end

  assign legal_resolve = bus.resolve_valid & cond_legal;

  always_comb begin
    valid_d       = bus.resolve_valid;
    illegal_d     = bus.resolve_valid & ~cond_legal;
    taken_d       = legal_resolve & cond_taken;
    mispredict_d  = legal_resolve & (cond_taken ^ bus.pred_in);

    entry_d = table_q[resolve_idx];
    if (cond_taken && entry_d != 2'b11) begin
      entry_d = entry_d + 2'b01;
    end else if (!cond_taken && entry_d != 2'b00) begin
      entry_d = entry_d - 2'b01;
    end

    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    // Clearing wins over a same-cycle resolve so software reads a clean zero afterwards.
    if (bus.clear_stats) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (legal_resolve) begin
      if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if (mispredict_d && mispred_cnt_q != '1) begin
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= 2'b01;
      end
      valid_q       <= 1'b0;
      taken_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      illegal_q     <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (legal_resolve) begin
        table_q[resolve_idx] <= entry_d;
      end
      valid_q       <= valid_d;
      taken_q       <= taken_d;
      mispredict_q  <= mispredict_d;
      illegal_q     <= illegal_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.valid_q      = valid_q;
  assign bus.taken_q      = taken_q;
  assign bus.mispredict_q = mispredict_q;
  assign bus.illegal_q    = illegal_q;
  assign bus.branch_cnt   = branch_cnt_q;
  assign bus.mispred_cnt  = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed vectors, hand sequences for the
// multi-cycle corner cases, and random traffic against a behavioural reference model.
module tb_branch_predict_unit;
  localparam int WIDTH   = 64;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  branch_predict_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  branch_predict_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: counters held as plain integers 0..3, stats as integers.
  int mdl_ctr [DEPTH];
  int mdl_branch;
  int mdl_mispred;
  bit exp_valid, exp_taken, exp_mis, exp_ill;

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic        p;
    logic        exp_taken;
    logic        exp_mis;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [11];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 2) % 64'(DEPTH));
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    longint sa = longint'(a);
    longint sb = longint'(b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl_ctr[i] = 1;
    mdl_branch = 0;
    mdl_mispred = 0;
    exp_valid = 0; exp_taken = 0; exp_mis = 0; exp_ill = 0;
  endtask

  task automatic check_all(input string tag);
    check_output({tag, ".valid_q"},      64'(bus.valid_q),      64'(exp_valid));
    check_output({tag, ".taken_q"},      64'(bus.taken_q),      64'(exp_taken));
    check_output({tag, ".mispredict_q"}, 64'(bus.mispredict_q), 64'(exp_mis));
    check_output({tag, ".illegal_q"},    64'(bus.illegal_q),    64'(exp_ill));
    check_output({tag, ".branch_cnt"},   64'(bus.branch_cnt),   64'(mdl_branch));
    check_output({tag, ".mispred_cnt"},  64'(bus.mispred_cnt),  64'(mdl_mispred));
  endtask

  // One clock of traffic: prediction checked before the edge, registered results after it.
  task automatic apply_stimulus(input logic v, input logic [63:0] pc, input logic [63:0] a,
                                input logic [63:0] b, input logic [2:0] f3, input logic p,
                                input logic c, input logic [63:0] lpc, input string tag);
    bit legal, t;
    @(negedge clk);
    bus.resolve_valid = v;
    bus.resolve_pc    = pc;
    bus.rs1           = a;
    bus.rs2           = b;
    bus.funct3        = f3;
    bus.pred_in       = p;
    bus.clear_stats   = c;
    bus.lookup_pc     = lpc;
    #1;
    check_output({tag, ".pred_taken"}, 64'(bus.pred_taken), 64'(mdl_ctr[idx_of(lpc)] >= 2));

    legal = !(f3 == 3'd2 || f3 == 3'd3);
    t = model_taken(f3, a, b);
    exp_valid = v;
    exp_ill   = v && !legal;
    exp_taken = v && legal && t;
    exp_mis   = v && legal && (t != p);
    if (c) begin
      mdl_branch = 0;
      mdl_mispred = 0;
    end else if (v && legal) begin
      if (mdl_branch < CNT_MAX) mdl_branch++;
      if (t != p && mdl_mispred < CNT_MAX) mdl_mispred++;
    end
    if (v && legal) begin
      if (t) mdl_ctr[idx_of(pc)] = (mdl_ctr[idx_of(pc)] == 3) ? 3 : mdl_ctr[idx_of(pc)] + 1;
      else   mdl_ctr[idx_of(pc)] = (mdl_ctr[idx_of(pc)] == 0) ? 0 : mdl_ctr[idx_of(pc)] - 1;
    end

    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_step(input logic c, input logic [63:0] lpc, input string tag);
    apply_stimulus(1'b0, 64'h0, 64'h0, 64'h0, 3'd0, 1'b0, c, lpc, tag);
  endtask

  function automatic logic [63:0] rand_operand(input logic [63:0] other);
    case ($urandom_range(0, 3))
      0:       return other;
      1:       return {$urandom(), $urandom()};
      2:       return 64'($signed(32'($urandom_range(0, 4)) - 32'sd2));
      default: return ($urandom_range(0, 1) == 1) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  initial begin
    logic [63:0] pc, lpc, a, b;

    vecs[0]  = '{3'd0, 64'd5, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 64'd5, 64'd6, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'd1, 64'd5, 64'd6, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{3'd4, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd5, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd4, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'd2, 64'd3, 64'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{3'd3, 64'd3, 64'd4, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_pc    = '0;
    bus.rs1           = '0;
    bus.rs2           = '0;
    bus.funct3        = '0;
    bus.pred_in       = 1'b0;
    bus.clear_stats   = 1'b0;
    bus.lookup_pc     = 64'h1234;
    model_reset();
    #12;
    check_output("reset.pred_taken", 64'(bus.pred_taken), 64'h0);
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] signed compare with mispredict");
    apply_stimulus(1'b1, 64'h84, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd4, 1'b0, 1'b0, 64'h84, "blt");
    check_output("blt.taken_const", 64'(bus.taken_q), 64'h1);
    check_output("blt.mispred_const", 64'(bus.mispred_cnt), 64'h1);

    $display("[TB] unsigned compares");
    apply_stimulus(1'b1, 64'h88, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd6, 1'b0, 1'b0, 64'h88, "bltu");
    check_output("bltu.taken_const", 64'(bus.taken_q), 64'h0);
    apply_stimulus(1'b1, 64'h88, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd7, 1'b0, 1'b0, 64'h88, "bgeu");
    check_output("bgeu.taken_const", 64'(bus.taken_q), 64'h1);

    $display("[TB] counter saturation at 0x40");
    check_output("sat.pred_initial", 64'(bus.pred_taken), 64'h0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 64'h40, 64'd9, 64'd9, 3'd0, 1'b1, 1'b0, 64'h40, "sat_up");
      check_output("sat.pred_up", 64'(bus.pred_taken), 64'h1);
    end
    apply_stimulus(1'b1, 64'h40, 64'd9, 64'd9, 3'd1, 1'b1, 1'b0, 64'h40, "sat_dn1");
    check_output("sat.pred_dn1", 64'(bus.pred_taken), 64'h1);
    apply_stimulus(1'b1, 64'h40, 64'd9, 64'd9, 3'd1, 1'b1, 1'b0, 64'h40, "sat_dn2");
    check_output("sat.pred_dn2", 64'(bus.pred_taken), 64'h0);

    $display("[TB] illegal funct3");
    idle_step(1'b1, 64'h3C, "clr");
    apply_stimulus(1'b1, 64'h3C, 64'd7, 64'd7, 3'd2, 1'b0, 1'b0, 64'h3C, "illegal");
    check_output("illegal.flag_const", 64'(bus.illegal_q), 64'h1);
    check_output("illegal.taken_const", 64'(bus.taken_q), 64'h0);
    check_output("illegal.branch_const", 64'(bus.branch_cnt), 64'h0);
    check_output("illegal.pred_const", 64'(bus.pred_taken), 64'h0);

    $display("[TB] reset during in-flight resolve");
    apply_stimulus(1'b1, 64'h40, 64'd1, 64'd1, 3'd0, 1'b0, 1'b0, 64'h40, "pump1");
    apply_stimulus(1'b1, 64'h40, 64'd1, 64'd1, 3'd0, 1'b0, 1'b0, 64'h40, "pump2");
    @(negedge clk);
    bus.resolve_valid = 1'b1;
    bus.resolve_pc    = 64'h40;
    bus.funct3        = 3'd0;
    bus.rs1           = 64'd1;
    bus.rs2           = 64'd1;
    bus.lookup_pc     = 64'h40;
    #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("midreset");
    check_output("midreset.pred_const", 64'(bus.pred_taken), 64'h0);
    @(negedge clk);
    bus.resolve_valid = 1'b0;
    reset = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(1'b1, 64'h100 + 64'(4 * i), vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].p,
                     1'b0, 64'h100 + 64'(4 * i), $sformatf("vec%0d", i));
      check_output($sformatf("vec%0d.taken_const", i), 64'(bus.taken_q), 64'(vecs[i].exp_taken));
      check_output($sformatf("vec%0d.mis_const", i), 64'(bus.mispredict_q), 64'(vecs[i].exp_mis));
      check_output($sformatf("vec%0d.ill_const", i), 64'(bus.illegal_q), 64'(vecs[i].exp_ill));
    end

    $display("[TB] statistics saturation and clear priority");
    idle_step(1'b1, 64'h0, "clr2");
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(1'b1, 64'h3C, 64'd1, 64'd1, 3'd0, 1'b0, 1'b0, 64'h3C, "mis17");
    end
    check_output("statsat.mispred_const", 64'(bus.mispred_cnt), 64'hF);
    check_output("statsat.branch_const", 64'(bus.branch_cnt), 64'hF);
    apply_stimulus(1'b1, 64'h3C, 64'd1, 64'd1, 3'd0, 1'b0, 1'b1, 64'h3C, "clrres");
    check_output("clrres.mispred_const", 64'(bus.mispred_cnt), 64'h0);
    check_output("clrres.branch_const", 64'(bus.branch_cnt), 64'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      pc  = {$urandom(), $urandom()};
      lpc = ($urandom_range(0, 1) == 1) ? pc : {$urandom(), $urandom()};
      a   = rand_operand(64'h0);
      b   = rand_operand(a);
      apply_stimulus(($urandom_range(0, 9) < 8), pc, a, b, 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), lpc, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
